ps2_kbd_rx: RTL and testbench
=============================

Name: ps2_kbd_rx

Overview:
PS/2 device-to-host receiver with byte FIFO. It is the producer side of the data/ready/nextdata_n scancode interface used by the keyboard display logic.
- Samples the ps2_clk/ps2_data pins in the clk domain and deframes 11-bit frames.
- Buffers good scancode bytes in the FIFO.
- Presents the FIFO head to the consumer; the consumer pops with a one-cycle low pulse on nextdata_n.

Parameters:
DEPTH_LOG2, 3, log2 of FIFO depth (default 8 entries); minimum 1.
SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data; minimum 2.
TIMEOUT_CYC, 50000, idle clk cycles mid-frame before frame abort; used only with PS2_TIMEOUT_EN.

Ports:
clk  in  1  system clock.
clrn  in  1  reset, asynchronous, active-low.
ps2_clk  in  1  PS/2 clock pin, asynchronous to clk.
ps2_data  in  1  PS/2 data pin, asynchronous to clk.
nextdata_n  in  1  active-low pop request from the consumer.
data  out  8  FIFO head byte; valid while ready=1.
ready  out  1  FIFO non-empty.
overflow  out  1  a good frame was dropped because the FIFO was full.
frame_err  out  1  one-cycle pulse when a frame fails the start, parity or stop check.

Behaviour:
Reset and clock domain
- One clock, clk. Reset is asynchronous, active-low, on clrn.
- clrn=0 clears: synchronisers (to 1), bit counter, shift register, FIFO pointers and count.
- Output reset values: ready=0, data=8'h00, overflow=0, frame_err=0.
- A reset mid-frame discards the partial frame. No byte from that frame is ever delivered.

Edge detection
- ps2_clk passes through SYNC_STAGES flops.
- A falling edge is last-two-stages == 2'b10 and produces a one-cycle neg pulse.
- ps2_data is sampled from its synchronised copy on the neg cycle.

Deframing
- Bit counter runs 0..10; each frame is 11 bits.
- Frame order: start (0), D0..D7 LSB first, odd parity, stop (1).
- On each neg, the sampled bit is shifted into a 10-bit register and the counter increments.
- On the 11th neg (counter==10), the counter returns to 0 and the frame is checked.
- Good frame: start==0, stop==1, and XOR of D0..D7 and parity ==1.
- A good frame pushes D[7:0] into the FIFO on that same clk edge.
- A bad frame pushes nothing and pulses frame_err for exactly one cycle.
- Latency: ready rises no more than SYNC_STAGES+1 clk cycles after the 11th ps2_clk falling edge at the pin.

FIFO and consumer handshake
- Pop occurs on any posedge where nextdata_n==0 and ready==1. The read pointer advances by one per cycle held low.
- nextdata_n==0 while ready==0 is ignored.
- data is driven combinationally from the head entry. data=8'h00 when the FIFO is empty.
- Push when full and no pop in the same cycle: the new byte is dropped, the FIFO is unchanged, and overflow is set.
- Push and pop in the same cycle when full: both occur, the count is unchanged, and there is no overflow.
- Push and pop in the same cycle when empty: push only.
- overflow is sticky. It clears on the next successful pop, or on reset.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. Full/empty come from a DEPTH_LOG2+1-bit count.

Optional Feature:
PS2_TIMEOUT_EN.
- Defined: an idle counter resets on every neg and increments while the bit counter is non-zero. When it reaches TIMEOUT_CYC, the bit counter returns to 0 and the partial frame is discarded without a frame_err pulse. This recovers from a glitch or a hot-plug mid-frame.
- Undefined: there is no idle counter, and the frame position persists indefinitely between edges.

Decomposition:
- Package ps2_pkg holds:
  - PS2_FRAME_BITS=11.
  - Scancode constants PS2_BREAK=8'hF0 and PS2_EXT=8'hE0.
  - A default FIFO depth constant.
- Sub-module ps2_fifo is a synchronous FIFO with push/pop/full/empty/head, parameterised by DEPTH_LOG2 and using the same clk/clrn.
- Synchroniser, edge detection and deframer stay in ps2_kbd_rx.

Test Plan:
- Single frame: frame 0x1C (bits 0,0,0,1,1,1,0,0,0,0,1; parity 0) -> ready=1, data=8'h1C; one-cycle nextdata_n=0 -> ready=0 the next cycle.
- Make/break sequence: frames 1C, F0, 1C, then three pops -> data 8'h1C, 8'hF0, 8'h1C in order; ready=0 after the third pop.
- Bad parity: frame 0x1C with parity=1 -> frame_err high for 1 cycle, ready stays 0; a following good 0x32 -> data=8'h32.
- Overflow: 9 good frames 0x01..0x09 with no pops -> overflow=1; the 8 pops return 0x01..0x08; overflow clears on the first pop.
- Reset mid-frame: clrn=0 after 5 bits of a frame, then released, then full frame 0x45 -> only 8'h45 delivered, no frame_err.
- With PS2_TIMEOUT_EN, TIMEOUT_CYC=100: 4 bits, idle 150 cycles, then full frame 0x29 -> data=8'h29, no frame_err. Without the macro, the same stimulus yields frame_err or a misaligned byte.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard receiver: frame geometry, common
// scancodes and the default FIFO depth.
package ps2_pkg;
   localparam int         PS2_FRAME_BITS     = 11;
   localparam logic [7:0] PS2_BREAK          = 8'hF0;
   localparam logic [7:0] PS2_EXT            = 8'hE0;
   localparam int         PS2_DEF_DEPTH_LOG2 = 3;

   // Odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [8:0] data_par);
      return ^data_par;
   endfunction
endpackage

// File: rtl/ps2_fifo.sv
// Byte FIFO between the PS/2 deframer and the scancode consumer; sticky
// overflow flag cleared by the next successful pop.
import ps2_pkg::*;

module ps2_fifo #(
   parameter int DEPTH_LOG2 = PS2_DEF_DEPTH_LOG2
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop_req,
   output logic [7:0] head,
   output logic       empty,
   output logic       full,
   output logic       overflow
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [7:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  do_pop, do_push;

   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));
   assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign overflow = ovf_q;

   always_comb begin
      do_pop   = pop_req & ~empty;
      // A pop frees a slot in the same cycle, so a full FIFO still accepts.
      do_push  = push & (~full | do_pop);
      wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      ovf_d    = ovf_q;
      if (do_pop)
         ovf_d = 1'b0;
      else if (push && full)
         ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= push_data;
   end
endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 device-to-host receiver: pin synchronisers, falling-edge detect,
// 11-bit deframer and scancode FIFO. PS2_TIMEOUT_EN adds a mid-frame idle abort.
import ps2_pkg::*;

module ps2_kbd_rx #(
   parameter int DEPTH_LOG2  = PS2_DEF_DEPTH_LOG2,
   parameter int SYNC_STAGES = 3,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       nextdata_n,
   output logic [7:0] data,
   output logic       ready,
   output logic       overflow,
   output logic       frame_err
);
   logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic [9:0]             sr_q, sr_d;
   logic                   frame_err_q, frame_err_d;
   logic                   neg, bit_in, push, fifo_empty, fifo_full_unused;

   assign neg       = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
   assign bit_in    = dat_sync_q[SYNC_STAGES-1];
   assign frame_err = frame_err_q;
   assign ready     = ~fifo_empty;

`ifdef PS2_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
   logic [IDLE_W-1:0] idle_q, idle_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_d  = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      frame_err_d = 1'b0;
      push        = 1'b0;
      if (neg) begin
         if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            // sr_q holds start at [0], D0..D7 at [8:1], parity at [9]; bit_in is stop.
            bit_cnt_d = '0;
            if (!sr_q[0] && bit_in && ps2_parity_ok(sr_q[9:1]))
               push = 1'b1;
            else
               frame_err_d = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sr_d      = {bit_in, sr_q[9:1]};
         end
      end
`ifdef PS2_TIMEOUT_EN
      idle_d = '0;
      if (!neg && bit_cnt_q != '0) begin
         if (idle_q == IDLE_W'(TIMEOUT_CYC))
            bit_cnt_d = '0;
         else
            idle_d = idle_q + IDLE_W'(1);
      end
`endif
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync_q  <= '1;
         dat_sync_q  <= '1;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         frame_err_q <= 1'b0;
      end else begin
         clk_sync_q  <= clk_sync_d;
         dat_sync_q  <= dat_sync_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         frame_err_q <= frame_err_d;
      end
   end

`ifdef PS2_TIMEOUT_EN
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) idle_q <= '0;
      else       idle_q <= idle_d;
   end
`endif

   ps2_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk       (clk),
      .clrn      (clrn),
      .push      (push),
      .push_data (sr_q[8:1]),
      .pop_req   (~nextdata_n),
      .head      (data),
      .empty     (fifo_empty),
      .full      (fifo_full_unused),
      .overflow  (overflow)
   );
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: bit-banged PS/2 frames, consumer pops and
// hand-computed expected bytes/flags.
module tb_ps2_kbd_rx;
   localparam int SYNC = 3;

   logic       clk = 1'b0, clrn = 1'b0;
   logic       ps2_clk = 1'b1, ps2_data = 1'b1, nextdata_n = 1'b1;
   logic [7:0] data;
   logic       ready, overflow, frame_err;
   int         n_chk = 0, n_fail = 0;
   int         err_cnt = 0, err_run = 0, err_max = 0;
   int         e0;

   ps2_kbd_rx #(.DEPTH_LOG2(3), .SYNC_STAGES(SYNC), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .nextdata_n(nextdata_n), .data(data), .ready(ready),
      .overflow(overflow), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_err) begin
         err_cnt++;
         err_run++;
         if (err_run > err_max) err_max = err_run;
      end else
         err_run = 0;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sends the first nbits of a frame for byte b; bad_par flips the parity bit.
   task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits,
                             input logic lat);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk) ps2_data = f[i];
         repeat (10) @(negedge clk);
         ps2_clk = 1'b0;
         if (lat && i == 10) begin
            repeat (SYNC + 1) @(posedge clk);
            #1 chk("latency_ready", ready, 1);
         end
         repeat (20) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk);
      end
      ps2_data = 1'b1;
   endtask

   task automatic pop();
      @(negedge clk) nextdata_n = 1'b0;
      @(negedge clk) nextdata_n = 1'b1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", ready, 0);
      chk("rst_data", data, 8'h00);
      chk("rst_ovf", overflow, 0);
      chk("rst_ferr", frame_err, 0);
      clrn = 1'b1;
      repeat (5) @(negedge clk);

      // single frame, checking pin-to-ready latency
      send_frame(8'h1C, 1'b0, 11, 1'b1);
      chk("single_ready", ready, 1);
      chk("single_data", data, 8'h1C);
      pop();
      chk("single_pop_ready", ready, 0);
      chk("single_pop_data", data, 8'h00);

      // pop request while empty is ignored
      repeat (3) pop();
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      send_frame(8'hF0, 1'b0, 11, 1'b0);
      send_frame(8'h1C, 1'b0, 11, 1'b0);
      chk("mb_data0", data, 8'h1C);
      pop();
      chk("mb_data1", data, 8'hF0);
      pop();
      chk("mb_data2", data, 8'h1C);
      pop();
      chk("mb_ready", ready, 0);
      chk("mb_no_err", err_cnt, 0);

      // bad parity
      send_frame(8'h1C, 1'b1, 11, 1'b0);
      chk("badpar_err_cnt", err_cnt, 1);
      chk("badpar_err_width", err_max, 1);
      chk("badpar_ready", ready, 0);
      send_frame(8'h32, 1'b0, 11, 1'b0);
      chk("after_bad_data", data, 8'h32);
      pop();
      chk("after_bad_ready", ready, 0);

      // overflow: nine frames into an eight-deep FIFO
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 11, 1'b0);
      chk("ovf_set", overflow, 1);
      for (int i = 1; i <= 8; i++) begin
         chk("ovf_data", data, 32'(i));
         pop();
         if (i == 1) chk("ovf_clear", overflow, 0);
      end
      chk("ovf_drain_ready", ready, 0);
      chk("ovf_no_err", err_cnt, 1);

      // reset mid-frame
      send_frame(8'hA5, 1'b0, 5, 1'b0);
      @(negedge clk) clrn = 1'b0;
      repeat (2) @(negedge clk);
      chk("midrst_ready", ready, 0);
      chk("midrst_data", data, 8'h00);
      clrn = 1'b1;
      repeat (5) @(negedge clk);
      e0 = err_cnt;
      send_frame(8'h45, 1'b0, 11, 1'b0);
      chk("midrst_new_data", data, 8'h45);
      pop();
      chk("midrst_only_one", ready, 0);
      chk("midrst_no_err", err_cnt - e0, 0);

      // four stray bits, long idle, then a full 0x29 frame
      e0 = err_cnt;
      send_frame(8'h00, 1'b0, 4, 1'b0);
      repeat (150) @(negedge clk);
      send_frame(8'h29, 1'b0, 11, 1'b0);
`ifdef PS2_TIMEOUT_EN
      chk("tmo_data", data, 8'h29);
      chk("tmo_ready", ready, 1);
      chk("tmo_no_err", err_cnt - e0, 0);
`else
      // without the abort the stray bits shift the frame and its parity fails
      chk("notmo_err", err_cnt - e0, 1);
      chk("notmo_ready", ready, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
